// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: default widths, FSM state encoding
// and the buffered payload layout (result, regwrite, rd, pc; MSB first).
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_RD_W   = 5;
  localparam int ALU_PC_W   = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  regwrite;
    logic [ALU_RD_W-1:0]   rd;
    logic [ALU_PC_W-1:0]   pc;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO payload buffer with valid/ready style push/pop and a synchronous flush.
// The head slot is never written while it is visible, so a stalled head stays stable.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      // Payload slots keep stale data; they are invisible once the count is zero.
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage output register: 2-entry skid buffer toward MEM plus an optional precise
// overflow trap (TRAP state, exc_valid pulse, epc) built only when ALU_OVF_TRAP_EN is defined.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int RD_W   = ALU_RD_W,
  parameter int PC_W   = ALU_PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_ovf,
  input  logic              in_trap_op,
  input  logic              in_regwrite,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_regwrite,
  output logic [RD_W-1:0]   out_rd,
  output logic [PC_W-1:0]   out_pc,
  output logic              exc_valid,
  output logic [PC_W-1:0]   epc,
  output state_t            o_dbg_state
);

  localparam int ENTRY_W = DATA_W + 1 + RD_W + PC_W;

  state_t             r_state;
  logic               r_in_ready;
  logic               w_acc;
  logic               w_rel;
  logic               w_push;
  logic               w_trap_acc;
  logic               w_out_valid;
  logic               w_entry_regwrite;
  logic [ENTRY_W-1:0] w_entry_in;
  logic [ENTRY_W-1:0] w_entry_out;

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and in_ready comes straight from a register.
  assign w_acc  = in_valid && r_in_ready;
  assign w_rel  = w_out_valid && out_ready;
  assign w_push = w_acc && (r_state != ST_TRAP);

`ifdef ALU_OVF_TRAP_EN
  logic            r_exc_valid;
  logic [PC_W-1:0] r_epc;

  assign w_trap_acc = w_acc && in_ovf && in_trap_op && (r_state != ST_TRAP) && !flush;
  assign exc_valid  = r_exc_valid;
  assign epc        = r_epc;
`else
  logic w_unused_trap_inputs;

  assign w_unused_trap_inputs = in_ovf ^ in_trap_op;
  assign w_trap_acc           = 1'b0;
  assign exc_valid            = 1'b0;
  assign epc                  = '0;
`endif

  // A trapped instruction still flows to MEM, but must not write back.
  assign w_entry_regwrite = in_regwrite && !w_trap_acc;
  assign w_entry_in       = {in_result, w_entry_regwrite, in_rd, in_pc};

  pipe_skid_buf #(
    .W(ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (w_entry_in),
    .i_pop   (w_rel),
    .o_valid (w_out_valid),
    .o_data  (w_entry_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
`ifdef ALU_OVF_TRAP_EN
      r_exc_valid <= 1'b0;
      r_epc       <= '0;
`endif
    end else begin
`ifdef ALU_OVF_TRAP_EN
      r_exc_valid <= 1'b0;
`endif
      if (flush) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b1;
      end else if (r_state == ST_TRAP) begin
        // Sink mode: keep accepting so upstream drains, but nothing is pushed.
        r_in_ready <= 1'b1;
      end else if (w_trap_acc) begin
        r_state    <= ST_TRAP;
        r_in_ready <= 1'b1;
`ifdef ALU_OVF_TRAP_EN
        r_exc_valid <= 1'b1;
        r_epc       <= in_pc;
`endif
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_acc) r_state <= ST_ONE;
          end
          ST_ONE: begin
            if (w_acc && !w_rel) begin
              r_state    <= ST_FULL;
              r_in_ready <= 1'b0;
            end else if (w_rel && !w_acc) begin
              r_state <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (w_rel) begin
              r_state    <= ST_ONE;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = w_out_valid;
  assign o_dbg_state = r_state;
  assign {out_result, out_regwrite, out_rd, out_pc} = w_entry_out;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table, hand sequences for stall/flush/
// trap/reset corners, a random burst, and a queue scoreboard checked every cycle.
module tb_alu_result_stage;
  import alu_pkg::*;

`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_ovf;
  logic        in_trap_op;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_regwrite;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        exc_valid;
  logic [31:0] epc;
  state_t      o_dbg_state;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_ovf       (in_ovf),
    .in_trap_op   (in_trap_op),
    .in_regwrite  (in_regwrite),
    .in_rd        (in_rd),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_regwrite (out_regwrite),
    .out_rd       (out_rd),
    .out_pc       (out_pc),
    .exc_valid    (exc_valid),
    .epc          (epc),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        trap_op;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[10];

  // ---------------- scoreboard / model ----------------
  logic [PAYLOAD_W-1:0] exp_q[$];
  logic        m_in_ready = 1'b1;
  logic        m_trap     = 1'b0;
  logic        m_exc      = 1'b0;
  logic [31:0] m_epc      = '0;
  logic        cur_exp_rw = 1'b0;
  int          n_chk      = 0;
  int          n_err      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_epc", epc, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_regwrite", out_regwrite, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_state", o_dbg_state, ST_EMPTY);
  endtask

  // Compare current outputs with the model, then advance one clock and update the model.
  task automatic tick(output logic acc);
    payload_t h;
    payload_t p;
    state_t   ms;
    logic     rel;
    logic     trap_acc;
    int       sz;
    sz = exp_q.size();
    ms = m_trap ? ST_TRAP : (sz == 0 ? ST_EMPTY : (sz == 1 ? ST_ONE : ST_FULL));
    chk("in_ready", in_ready, m_in_ready);
    chk("out_valid", out_valid, sz != 0);
    chk("state", o_dbg_state, ms);
    chk("exc_valid", exc_valid, m_exc);
    chk("epc", epc, m_epc);
    if (sz != 0) begin
      h = payload_t'(exp_q[0]);
      chk("out_result", out_result, h.result);
      chk("out_regwrite", out_regwrite, h.regwrite);
      chk("out_rd", out_rd, h.rd);
      chk("out_pc", out_pc, h.pc);
    end
    acc = in_valid && m_in_ready;
    rel = (sz != 0) && out_ready;
    m_exc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_trap = 1'b0;
      m_epc  = '0;
    end else if (flush) begin
      exp_q.delete();
      m_trap = 1'b0;
    end else begin
      if (rel) void'(exp_q.pop_front());
      if (acc && !m_trap) begin
        trap_acc   = TRAP_EN && in_ovf && in_trap_op;
        p.result   = in_result;
        p.regwrite = trap_acc ? 1'b0 : cur_exp_rw;
        p.rd       = in_rd;
        p.pc       = in_pc;
        exp_q.push_back(p);
        if (trap_acc) begin
          m_trap = 1'b1;
          m_exc  = 1'b1;
          m_epc  = in_pc;
        end
      end
    end
    m_in_ready = m_trap || (exp_q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input int i);
    in_valid    = 1'b1;
    in_result   = vecs[i].result;
    in_ovf      = vecs[i].ovf;
    in_trap_op  = vecs[i].trap_op;
    in_regwrite = vecs[i].regwrite;
    in_rd       = vecs[i].rd;
    in_pc       = vecs[i].pc;
    cur_exp_rw  = vecs[i].exp_rw;
  endtask

  task automatic send(input int i);
    logic a;
    a = 1'b0;
    apply(i);
    for (int k = 0; k < 20 && !a; k++) tick(a);
    if (!a) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: vector %0d not accepted within 20 cycles", i);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    in_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic a;
    //              result        ovf   trap  rw    rd     pc             exp_rw
    vecs[0] = '{32'h0000_0005, 1'b0, 1'b1, 1'b1, 5'd1,  32'h0040_0000, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd2,  32'h0040_0004, 1'b1};
    vecs[2] = '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd3,  32'h0040_0008, 1'b1};  // ADDU overflow
    vecs[3] = '{32'h0000_0001, 1'b1, 1'b0, 1'b1, 5'd4,  32'h0040_000C, 1'b1};  // SLT 0x80000000<1
    vecs[4] = '{32'h1234_5678, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0040_0010, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 5'd31, 32'h0040_0014, 1'b1};
    vecs[6] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0040_0018, 1'b1};
    vecs[7] = '{32'hA5A5_A5A5, 1'b0, 1'b1, 1'b1, 5'd17, 32'h0040_001C, 1'b1};
    vecs[8] = '{32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd9,  32'h0040_0100, !TRAP_EN};  // ADD 7FFFFFFF+1
    vecs[9] = '{32'h0000_0042, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0040_0104, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_ovf = 1'b0; in_trap_op = 1'b0;
    in_regwrite = 1'b0; in_rd = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;

    // Full-throughput stream of 8 (includes ADDU and SLT overflow, which never trap)
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(i);
    idle(3);

    // Stall: two accepts fill the buffer, the third waits and is not lost
    out_ready = 1'b0;
    send(0);
    send(1);
    apply(2);
    tick(a);
    tick(a);
    out_ready = 1'b1;
    send(2);
    idle(3);

    // Flush while FULL with input presented, then flush against an accept in ONE
    out_ready = 1'b0;
    send(4);
    send(5);
    apply(6);
    flush = 1'b1;
    tick(a);
    flush = 1'b0;
    send(3);
    apply(7);
    flush = 1'b1;
    tick(a);
    flush = 1'b0;
    idle(2);

    // Overflow trap behind an older entry, followed by inputs that must be discarded
    out_ready = 1'b0;
    send(5);
    send(8);
    out_ready = 1'b1;
    send(9);
    send(7);
    idle(4);
    in_valid = 1'b0;
    flush = 1'b1;
    tick(a);
    flush = 1'b0;
    idle(2);

    // Random traffic, non-trapping ops only
    for (int c = 0; c < 300; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      in_result   = $urandom;
      in_ovf      = $urandom_range(0, 1);
      in_trap_op  = 1'b0;
      in_regwrite = $urandom_range(0, 1);
      in_rd       = 5'($urandom_range(0, 31));
      in_pc       = $urandom;
      cur_exp_rw  = in_regwrite;
      tick(a);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Reset with two entries buffered (and the trap active when built in)
    out_ready = 1'b0;
    send(0);
    send(8);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick(a);
    chk_reset();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
